// File: rtl/muldiv_issue_ctrl_if.sv
// -----------------------------------------------------------------------------
// muldiv_issue_ctrl_if
// Bundles the execute-stage handshake and the functional-unit handshakes that
// muldiv_issue_ctrl talks over.
//   slave  : the issue controller (samples instruction/unit inputs, drives
//            in_ready, start pulses, stall and the result bus)
//   master : the surrounding pipeline and functional units
// Signals:
//   in_valid/in_ready            instruction handshake
//   f7, f3, rs1_val, rs2_val     decoded fields and operands
//   alu_result                   combinational ALU output
//   md_start/md_done/md_result   iterative mul/div unit handshake
//   cx_start/cx_done/cx_result   custom-op unit handshake
//   stall                        pipeline hold
//   out_valid/out_result/out_err result pulse, registered result, error flag
// -----------------------------------------------------------------------------
interface muldiv_issue_ctrl_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [6:0]      f7;
    logic [2:0]      f3;
    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;
    logic [XLEN-1:0] alu_result;
    logic            md_start;
    logic            md_done;
    logic [XLEN-1:0] md_result;
    logic            cx_start;
    logic            cx_done;
    logic [XLEN-1:0] cx_result;
    logic            stall;
    logic            out_valid;
    logic [XLEN-1:0] out_result;
    logic            out_err;

    modport slave (
        input  in_valid, f7, f3, rs1_val, rs2_val, alu_result,
        input  md_done, md_result, cx_done, cx_result,
        output in_ready, md_start, cx_start, stall,
        output out_valid, out_result, out_err
    );

    modport master (
        output in_valid, f7, f3, rs1_val, rs2_val, alu_result,
        output md_done, md_result, cx_done, cx_result,
        input  in_ready, md_start, cx_start, stall,
        input  out_valid, out_result, out_err
    );
endinterface

// File: rtl/muldiv_issue_ctrl.sv
// -----------------------------------------------------------------------------
// muldiv_issue_ctrl
// Execute-stage issue controller. Routes each accepted instruction to the ALU
// (single cycle), the iterative mul/div unit or the custom-op unit, sequences
// the start/done handshake, resolves divide-by-zero and signed-overflow
// without launching the divider, and flags illegal funct7 and unit timeouts.
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : muldiv_issue_ctrl_if.slave (instruction in, unit handshakes,
//          stall, result out)
// Parameters:
//   XLEN    : operand/result width
//   TIMEOUT : cycles to wait for a unit done before flagging an error (>=2)
// -----------------------------------------------------------------------------
module muldiv_issue_ctrl #(
    parameter int XLEN    = 32,
    parameter int TIMEOUT = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    muldiv_issue_ctrl_if.slave   bus
);
    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [XLEN-1:0]  SIGNED_MIN = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_MD = 2'd1,
        WAIT_CX = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [XLEN-1:0]  res_q, res_d;
    logic             err_q, err_d;

    // Handshake of whichever unit the current wait state is talking to.
    logic             unit_done;
    logic [XLEN-1:0]  unit_result;

    assign unit_done   = (state_q == WAIT_MD) ? bus.md_done   : bus.cx_done;
    assign unit_result = (state_q == WAIT_MD) ? bus.md_result : bus.cx_result;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a variable unassigned and no latch is inferred.
        state_d = state_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        err_d   = err_q;

        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (bus.in_valid) begin
                    case (bus.f7)
                        7'h00, 7'h20: begin
                            state_d = DONE;
                            res_d   = bus.alu_result;
                            err_d   = 1'b0;
                        end
                        7'h01: begin
                            if (!bus.f3[2]) begin
                                state_d = WAIT_MD;
                            end else if (bus.rs2_val == '0) begin
                                // Divide by zero: quotient all ones, remainder rs1.
                                state_d = DONE;
                                res_d   = bus.f3[1] ? bus.rs1_val : '1;
                                err_d   = 1'b0;
                            end else if (!bus.f3[0] && bus.rs1_val == SIGNED_MIN
                                         && bus.rs2_val == '1) begin
                                // Signed overflow: quotient rs1, remainder 0.
                                state_d = DONE;
                                res_d   = bus.f3[1] ? '0 : bus.rs1_val;
                                err_d   = 1'b0;
                            end else begin
                                state_d = WAIT_MD;
                            end
                        end
                        7'h02, 7'h03: state_d = WAIT_CX;
                        default: begin
                            state_d = DONE;
                            res_d   = '0;
                            err_d   = 1'b1;
                        end
                    endcase
                end
            end
            WAIT_MD, WAIT_CX: begin
                cnt_d = cnt_q + 1'b1;
                // done is ignored in the start cycle (cnt_q == 0); it takes
                // priority over a timeout landing in the same cycle.
                if (cnt_q != '0 && unit_done) begin
                    state_d = DONE;
                    res_d   = unit_result;
                    err_d   = 1'b0;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = DONE;
                    res_d   = '0;
                    err_d   = 1'b1;
                    cnt_d   = '0;
                end
            end
            DONE: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of the others, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            res_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            err_q   <= err_d;
        end
    end

    // All outputs decode registered state only: no input-to-output path.
    assign bus.in_ready   = (state_q == IDLE);
    assign bus.stall      = (state_q != IDLE);
    assign bus.md_start   = (state_q == WAIT_MD) && (cnt_q == '0);
    assign bus.cx_start   = (state_q == WAIT_CX) && (cnt_q == '0);
    assign bus.out_valid  = (state_q == DONE);
    assign bus.out_result = res_q;
    assign bus.out_err    = err_q;

endmodule
